// File: rtl/fp32_pkg.sv
// ============================================================================
// fp32_pkg : shared constants, FSM state type and operand classifiers for the
//            fp32 arithmetic library (divider and multiplier).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

   localparam int         EXP_BIAS  = 127;
   localparam logic [7:0] EXP_MAX   = 8'hFF;
   localparam logic [22:0] QNAN_FRAC = 23'h400000;

   localparam int FLAG_INVALID = 3;
   localparam int FLAG_DIVZERO = 2;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_UNDERFLOW = 0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DIVIDE     = 2'd1,
      NORM_ROUND = 2'd2,
      DONE       = 2'd3
   } div_state_t;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
   endfunction

   // Denormals are flushed, so a zero exponent alone means zero.
   function automatic logic is_zero(input logic [31:0] x);
      return x[30:23] == 8'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_nbit.sv
// ============================================================================
// adder_nbit : WIDTH-bit adder with carry-in; IMPL_TYPE 0 = inferred adder,
//              otherwise an explicit ripple-carry chain.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_nbit #(
   parameter int WIDTH     = 8,
   parameter int IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);

   generate
      if (IMPL_TYPE == 0) begin : g_behav
         assign sum = a + b + WIDTH'(cin);
      end else begin : g_ripple
         logic [WIDTH-1:0] carry;
         assign carry[0] = cin;
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
            if (gi < WIDTH - 1) begin : g_carry
               assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/fp32_div_step.sv
// ============================================================================
// fp32_div_step : one combinational restoring-division step; produces the
//                 quotient bit and the shifted partial remainder.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module fp32_div_step #(
   parameter int WIDTH     = 26,
   parameter int IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   logic [WIDTH:0] diff;

   // One extra bit so the sign of rem - divisor is the trial outcome.
   adder_nbit #(
      .WIDTH     (WIDTH + 1),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_trial_sub (
      .a   ({1'b0, rem}),
      .b   (~{1'b0, divisor}),
      .cin (1'b1),
      .sum (diff)
   );

   assign q_bit    = ~diff[WIDTH];
   assign next_rem = (q_bit ? diff[WIDTH-1:0] : rem) << 1;

endmodule

`default_nettype wire

// File: rtl/fp32_divider_seq.sv
// ============================================================================
// fp32_divider_seq : iterative IEEE-754 single-precision divider, one radix-2
//                    restoring step per clock, RNE rounding, flush-to-zero.
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module fp32_divider_seq
   import fp32_pkg::*;
#(
   parameter int IMPL_TYPE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   localparam int REM_W = 26;

   div_state_t        state;
   logic [4:0]        cnt;
   logic              sign;
   logic signed [9:0] exp_r;
   logic [REM_W-1:0]  rem;
   logic [23:0]       div_m;
   logic [25:0]       q;
   logic              norm_phase;
   logic [22:0]       norm_frac;
   logic              norm_guard;
   logic              norm_sticky;
   logic signed [9:0] norm_exp;

   logic              in_sign;
   logic [9:0]        exp_sub;
   logic signed [9:0] exp_diff;
   logic [REM_W-1:0]  step_rem;
   logic              step_q;
   logic              special;
   logic [31:0]       spec_result;
   logic [3:0]        spec_flags;
   logic              rnd_inc;
   logic [23:0]       rnd;
   logic signed [9:0] fin_exp;
   logic [22:0]       fin_frac;

   assign in_sign = a[31] ^ b[31];

   adder_nbit #(
      .WIDTH     (10),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_exp_sub (
      .a   ({2'b00, a[30:23]}),
      .b   (~{2'b00, b[30:23]}),
      .cin (1'b1),
      .sum (exp_sub)
   );

   assign exp_diff = $signed(exp_sub) + 10'sd127;

   fp32_div_step #(
      .WIDTH     (REM_W),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_step (
      .rem      (rem),
      .divisor  ({2'b00, div_m}),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   always_comb begin
      special     = 1'b1;
      spec_result = {in_sign, EXP_MAX, QNAN_FRAC};
      spec_flags  = 4'd0;
      if (is_nan(a) || is_nan(b)) begin
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) begin
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if (is_inf(a)) begin
         spec_result = {in_sign, EXP_MAX, 23'd0};
      end else if (is_zero(b)) begin
         spec_result = {in_sign, EXP_MAX, 23'd0};
         spec_flags[FLAG_DIVZERO] = 1'b1;
      end else if (is_zero(a) || is_inf(b)) begin
         spec_result = {in_sign, 31'd0};
      end else begin
         special = 1'b0;
      end
   end

   // Rounding works on the normalized fields registered one cycle earlier.
   assign rnd_inc  = norm_guard & (norm_sticky | norm_frac[0]);
   assign rnd      = {1'b0, norm_frac} + {23'd0, rnd_inc};
   assign fin_exp  = rnd[23] ? norm_exp + 10'sd1 : norm_exp;
   assign fin_frac = rnd[23] ? 23'd0 : rnd[22:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         result      <= 32'd0;
         flags       <= 4'd0;
         cnt         <= 5'd0;
         sign        <= 1'b0;
         exp_r       <= 10'sd0;
         rem         <= '0;
         div_m       <= 24'd0;
         q           <= 26'd0;
         norm_phase  <= 1'b0;
         norm_frac   <= 23'd0;
         norm_guard  <= 1'b0;
         norm_sticky <= 1'b0;
         norm_exp    <= 10'sd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  sign     <= in_sign;
                  if (special) begin
                     result    <= spec_result;
                     flags     <= spec_flags;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rem   <= {2'b01, a[22:0], 1'b0} >> 1;
                     div_m <= {1'b1, b[22:0]};
                     exp_r <= exp_diff;
                     q     <= 26'd0;
                     cnt   <= 5'd0;
                     state <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               q   <= {q[24:0], step_q};
               rem <= step_rem;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd25) begin
                  norm_phase <= 1'b0;
                  state      <= NORM_ROUND;
               end
            end
            NORM_ROUND: begin
               if (!norm_phase) begin
                  norm_phase <= 1'b1;
                  if (q[25]) begin
                     norm_frac   <= q[24:2];
                     norm_guard  <= q[1];
                     norm_sticky <= q[0] | (|rem);
                     norm_exp    <= exp_r;
                  end else begin
                     norm_frac   <= q[23:1];
                     norm_guard  <= q[0];
                     norm_sticky <= |rem;
                     norm_exp    <= exp_r - 10'sd1;
                  end
               end else begin
                  flags <= 4'd0;
                  if (fin_exp >= 10'sd255) begin
                     result <= {sign, EXP_MAX, 23'd0};
                     flags[FLAG_OVERFLOW] <= 1'b1;
                  end else if (fin_exp <= 10'sd0) begin
                     result <= {sign, 31'd0};
                     flags[FLAG_UNDERFLOW] <= 1'b1;
                  end else begin
                     result <= {sign, fin_exp[7:0], fin_frac};
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp32_divider_seq.sv
// ============================================================================
// tb_fp32_divider_seq : scoreboard bench for fp32_divider_seq with directed,
//                       hand-computed vectors.
// Revision            : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp32_divider_seq;

   localparam int LAT_SPECIAL = 0;
   localparam int LAT_NORMAL  = 28;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [3:0]  flags;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_ov = 1'b0;

   fp32_divider_seq #(.IMPL_TYPE(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Monitor: latency on the rising edge of out_valid, data on handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("flags", {28'd0, flags}, {28'd0, e.fl});
         end
      end
      prev_ov = out_valid;
   end

   task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] res, input logic [3:0] fl, input int lat);
      int n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      a = op_a;
      b = op_b;
      in_valid = 1'b1;
      sb.push_back('{res, fl, lat, cyc + 1});
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF;
      b = 32'h0BAD_F00D;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      int n;
      #23;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {28'd0, flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NORMAL); wait_drain();
      do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, LAT_NORMAL); wait_drain();
      do_op(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000, LAT_NORMAL); wait_drain();
      do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, LAT_SPECIAL); wait_drain();
      do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, LAT_SPECIAL); wait_drain();
      do_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, LAT_SPECIAL); wait_drain();
      do_op(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, LAT_SPECIAL); wait_drain();
      do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, LAT_SPECIAL); wait_drain();
      do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, LAT_SPECIAL); wait_drain();
      do_op(32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010, LAT_NORMAL); wait_drain();
      do_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, LAT_NORMAL); wait_drain();

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NORMAL);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("bp_out_valid_timeout", 32'd0, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_result", result, 32'h40400000);
         chk("bp_hold_flags_ready", {27'd0, out_valid, flags, in_ready}, {27'd0, 1'b1, 4'b0000, 1'b0});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
      wait_drain();
      do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, LAT_NORMAL); wait_drain();

      // Reset in the middle of DIVIDE aborts the operation.
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NORMAL);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NORMAL); wait_drain();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
